// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry, MRET return and a registered redirect
// handshake toward fetch. Privilege is either M (3) or U (0).
module csr_trap_unit #(
    parameter int unsigned     XLEN      = 64,
    parameter int unsigned     NIRQ      = 12,
    parameter bit              VEC_EN    = 1'b1,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    input  logic            cm_valid,
    output logic            cm_ready,
    input  logic [2:0]      cm_op,
    input  logic [XLEN-1:0] cm_pc,
    input  logic [11:0]     cm_addr,
    input  logic [XLEN-1:0] cm_wdata,
    input  logic [3:0]      cm_cause,
    input  logic [XLEN-1:0] cm_tval,
    input  logic [NIRQ-1:0] irq,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic [1:0]      priv
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    localparam logic [2:0] OP_CSRRW = 3'd1;
    localparam logic [2:0] OP_CSRRS = 3'd2;
    localparam logic [2:0] OP_CSRRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;
    localparam logic [2:0] OP_EXC   = 3'd6;

    localparam logic [XLEN-1:0] ALIGN4     = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 1'b0, VEC_EN};

    typedef enum logic {IDLE, REDIR} state_t;
    state_t state_q, state_d;

    logic            status_mie, status_mpie;
    logic [1:0]      status_mpp, priv_q;
    logic [NIRQ-1:0] mie_q, mip_q;
    logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
    logic [XLEN-1:0] mcycle_q, minstret_q, redir_pc_q;
    logic [XLEN-1:0] mstatus_val;

    assign mstatus_val = XLEN'({status_mpp, 3'b000, status_mpie, 3'b000, status_mie, 3'b000});

    function automatic logic [XLEN-1:0] read_csr(input logic [11:0] addr);
        case (addr)
            A_MSTATUS:  read_csr = mstatus_val;
            A_MIE:      read_csr = XLEN'(mie_q);
            A_MIP:      read_csr = XLEN'(mip_q);
            A_MTVEC:    read_csr = mtvec_q;
            A_MEPC:     read_csr = mepc_q;
            A_MCAUSE:   read_csr = mcause_q;
            A_MTVAL:    read_csr = mtval_q;
            A_MSCRATCH: read_csr = mscratch_q;
            A_MCYCLE:   read_csr = mcycle_q;
            A_MINSTRET: read_csr = minstret_q;
            default:    read_csr = '0;
        endcase
    endfunction

    logic [XLEN-1:0] csr_old, csr_new, trap_target, target;
    logic [NIRQ-1:0] irq_vec;
    logic [3:0]      irq_code, trap_code;
    logic            irq_take, accept, is_sync, is_csr, take_trap, trap_irq;
    logic            do_csr, do_mret, csr_we, go_redir;

    assign rd_data = read_csr(rd_addr);
    assign csr_old = read_csr(cm_addr);

    // Interrupts are masked in M-mode unless MIE is set; the highest index wins.
    assign irq_vec  = mip_q & mie_q;
    assign irq_take = (|irq_vec) && (priv_q != 2'd3 || status_mie);

    always_comb begin
        irq_code = 4'd0;
        for (int i = 0; i < NIRQ; i++) begin
            if (irq_vec[i]) irq_code = 4'(i);
        end
    end

    assign accept    = cm_valid && (state_q == IDLE);
    assign is_sync   = (cm_op == OP_ECALL) || (cm_op == OP_EXC);
    assign is_csr    = (cm_op == OP_CSRRW) || (cm_op == OP_CSRRS) || (cm_op == OP_CSRRC);
    assign take_trap = accept && (is_sync || irq_take);
    assign trap_irq  = !is_sync;
    assign do_csr    = accept && !take_trap && is_csr;
    assign do_mret   = accept && !take_trap && (cm_op == OP_MRET);
    assign csr_we    = do_csr && (cm_op == OP_CSRRW || cm_wdata != '0);
    assign go_redir  = take_trap || do_csr || do_mret;

    always_comb begin
        trap_code = irq_code;
        if (cm_op == OP_EXC)        trap_code = cm_cause;
        else if (cm_op == OP_ECALL) trap_code = (priv_q == 2'd3) ? 4'd11 : 4'd8;
    end

    always_comb begin
        case (cm_op)
            OP_CSRRS: csr_new = csr_old | cm_wdata;
            OP_CSRRC: csr_new = csr_old & ~cm_wdata;
            default:  csr_new = cm_wdata;
        endcase
    end

    assign trap_target = (mtvec_q & ALIGN4) +
                         ((trap_irq && mtvec_q[0]) ? XLEN'({trap_code, 2'b00}) : '0);

    always_comb begin
        target = mepc_q;
        if (take_trap)   target = trap_target;
        else if (do_csr) target = cm_pc + XLEN'(4);
    end

    // Counters step first so that a same-cycle CSR write overrides them.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            status_mpp  <= 2'b00;
            priv_q      <= 2'd3;
            mie_q       <= '0;
            mip_q       <= '0;
            mtvec_q     <= RESET_VEC & MTVEC_MASK;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            mscratch_q  <= '0;
            mcycle_q    <= '0;
            minstret_q  <= '0;
        end else begin
            mip_q    <= irq;
            mcycle_q <= mcycle_q + XLEN'(1);
            if (accept && !take_trap) minstret_q <= minstret_q + XLEN'(1);
            if (take_trap) begin
                mepc_q      <= cm_pc & ALIGN4;
                mcause_q    <= {trap_irq, {(XLEN-5){1'b0}}, trap_code};
                mtval_q     <= (cm_op == OP_EXC) ? cm_tval : '0;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
                status_mpp  <= priv_q;
                priv_q      <= 2'd3;
            end else if (do_mret) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
                priv_q      <= status_mpp;
                status_mpp  <= 2'b00;
            end else if (csr_we) begin
                case (cm_addr)
                    A_MSTATUS: begin
                        status_mie  <= csr_new[3];
                        status_mpie <= csr_new[7];
                        status_mpp  <= {2{&csr_new[12:11]}};
                    end
                    A_MIE:      mie_q      <= csr_new[NIRQ-1:0];
                    A_MTVEC:    mtvec_q    <= csr_new & MTVEC_MASK;
                    A_MEPC:     mepc_q     <= csr_new & ALIGN4;
                    A_MCAUSE:   mcause_q   <= csr_new;
                    A_MTVAL:    mtval_q    <= csr_new;
                    A_MSCRATCH: mscratch_q <= csr_new;
                    A_MCYCLE:   mcycle_q   <= csr_new;
                    A_MINSTRET: minstret_q <= csr_new;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset)         redir_pc_q <= '0;
        else if (go_redir) redir_pc_q <= target;
    end

    always_comb begin
        state_d     = state_q;
        cm_ready    = 1'b0;
        redir_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cm_ready = 1'b1;
                if (go_redir) state_d = REDIR;
            end
            REDIR: begin
                redir_valid = 1'b1;
                if (redir_ready) state_d = IDLE;
            end
        endcase
    end

    assign redir_pc = redir_pc_q;
    assign priv     = priv_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios with literal expectations, then
// random commits, all checked every cycle against a behavioural CSR model.
module tb_csr_trap_unit;

    localparam int NIRQ = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rd_addr = 12'h0;
    logic [63:0] rd_data;
    logic        cm_valid = 1'b0;
    logic        cm_ready;
    logic [2:0]  cm_op = 3'd0;
    logic [63:0] cm_pc = 64'h0;
    logic [11:0] cm_addr = 12'h0;
    logic [63:0] cm_wdata = 64'h0;
    logic [3:0]  cm_cause = 4'h0;
    logic [63:0] cm_tval = 64'h0;
    logic [NIRQ-1:0] irq = '0;
    logic        redir_valid;
    logic        redir_ready = 1'b0;
    logic [63:0] redir_pc;
    logic [1:0]  priv;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    csr_trap_unit #(.XLEN(64), .NIRQ(NIRQ), .VEC_EN(1'b1), .RESET_VEC(64'h0)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_op(cm_op), .cm_pc(cm_pc),
        .cm_addr(cm_addr), .cm_wdata(cm_wdata), .cm_cause(cm_cause), .cm_tval(cm_tval),
        .irq(irq), .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .priv(priv)
    );

    // Architectural state of the model, one variable per CSR.
    logic [63:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mscratch, m_mcycle, m_minstret, m_redir_pc;
    logic [1:0]  m_priv;
    bit          m_redir;

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [63:0] v,
                               output bit w_cyc, output bit w_ins);
        w_cyc = 1'b0;
        w_ins = 1'b0;
        case (a)
            12'h300: m_mstatus = (v & 64'h88) | ((v[12:11] == 2'b11) ? 64'h1800 : 64'h0);
            12'h304: m_mie = v & ((64'd1 << NIRQ) - 64'd1);
            12'h305: m_mtvec = v & ~64'h2;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~64'h3;
            12'h342: m_mcause = v;
            12'h343: m_mtval = v;
            12'hB00: begin m_mcycle = v; w_cyc = 1'b1; end
            12'hB02: begin m_minstret = v; w_ins = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic model_step();
        logic [63:0] old_v, new_v, tgt, pend;
        logic [3:0]  code;
        bit acc, trap, is_irq, act, w_cyc, w_ins, prev_mpie;
        int hi;
        if (reset) begin
            m_mstatus = 0; m_mie = 0; m_mip = 0; m_mtvec = 64'h0; m_mepc = 0;
            m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_mcycle = 0; m_minstret = 0;
            m_priv = 2'd3; m_redir = 1'b0; m_redir_pc = 0;
            return;
        end
        acc = cm_valid && !m_redir;
        pend = m_mip & m_mie;
        hi = -1;
        for (int i = 0; i < NIRQ; i++) if (pend[i]) hi = i;
        act = 0; trap = 0; is_irq = 0; w_cyc = 0; w_ins = 0; tgt = 0; code = 0;
        if (acc) begin
            if (cm_op == 3'd4 || cm_op == 3'd6) begin
                trap = 1;
                code = (cm_op == 3'd6) ? cm_cause : ((m_priv == 2'd0) ? 4'd8 : 4'd11);
            end else if (hi >= 0 && (m_priv != 2'd3 || m_mstatus[3])) begin
                trap = 1; is_irq = 1; code = 4'(hi);
            end
        end
        if (trap) begin
            m_mepc = {cm_pc[63:2], 2'b00};
            m_mcause = {is_irq, 59'd0, code};
            m_mtval = (cm_op == 3'd6) ? cm_tval : 64'h0;
            m_mstatus = {51'd0, m_priv, 3'd0, m_mstatus[3], 7'd0};
            m_priv = 2'd3;
            tgt = {m_mtvec[63:2], 2'b00} + ((is_irq && m_mtvec[0]) ? 64'(code) * 4 : 64'h0);
            act = 1;
        end else if (acc && cm_op >= 3'd1 && cm_op <= 3'd3) begin
            old_v = model_read(cm_addr);
            case (cm_op)
                3'd1:    new_v = cm_wdata;
                3'd2:    new_v = old_v | cm_wdata;
                default: new_v = old_v & ~cm_wdata;
            endcase
            if (cm_op == 3'd1 || cm_wdata != 0) model_write(cm_addr, new_v, w_cyc, w_ins);
            tgt = cm_pc + 64'd4;
            act = 1;
        end else if (acc && cm_op == 3'd5) begin
            tgt = m_mepc;
            prev_mpie = m_mstatus[7];
            m_priv = m_mstatus[12:11];
            m_mstatus = {56'd0, 1'b1, 3'd0, prev_mpie, 3'd0};
            act = 1;
        end
        if (!w_cyc) m_mcycle = m_mcycle + 64'd1;
        if (acc && !trap && !w_ins) m_minstret = m_minstret + 64'd1;
        m_mip = 64'(irq);
        if (m_redir) begin
            if (redir_ready) m_redir = 1'b0;
        end else if (act) begin
            m_redir = 1'b1;
            m_redir_pc = tgt;
        end
    endtask

    always @(posedge clk) model_step();

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("cm_ready", 64'(cm_ready), 64'(!m_redir));
            check_output("redir_valid", 64'(redir_valid), 64'(m_redir));
            if (m_redir) check_output("redir_pc", redir_pc, m_redir_pc);
            check_output("priv", 64'(priv), 64'(m_priv));
            check_output("rd_data", rd_data, model_read(rd_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [11:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] pc,
                                  input logic [3:0] cause, input logic [63:0] tval);
        cm_valid = 1'b1; cm_op = op; cm_addr = addr; cm_wdata = wdata;
        cm_pc = pc; cm_cause = cause; cm_tval = tval;
        tick();
        cm_valid = 1'b0; cm_op = 3'd0;
    endtask

    task automatic drain();
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
    endtask

    task automatic expect_csr(input string name, input logic [11:0] a, input logic [63:0] exp);
        rd_addr = a;
        @(negedge clk);
        check_output(name, rd_data, exp);
        check_output({name, "_model"}, model_read(a), exp);
        #1;
    endtask

    task automatic expect_redir(input string name, input logic exp_valid, input logic [63:0] exp_pc);
        @(negedge clk);
        check_output({name, "_valid"}, 64'(redir_valid), 64'(exp_valid));
        check_output({name, "_ready"}, 64'(cm_ready), 64'(!exp_valid));
        if (exp_valid) check_output({name, "_pc"}, redir_pc, exp_pc);
        #1;
    endtask

    logic [11:0] addr_tab [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hB00, 12'hB02, 12'h7C0, 12'h301};
    logic [63:0] saved;
    int r;

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        expect_redir("reset", 1'b0, 64'h0);
        @(negedge clk);
        check_output("reset_priv", 64'(priv), 64'd3);
        #1;
        expect_csr("reset_mcycle", 12'hB00, 64'd2);

        // Direct-mode synchronous exception.
        apply_stimulus(3'd1, 12'h305, 64'h100, 64'h0, 4'd0, 64'h0);
        drain();
        apply_stimulus(3'd6, 12'h0, 64'h0, 64'h8000_0010, 4'd2, 64'hdead);
        expect_redir("exc", 1'b1, 64'h100);
        expect_csr("exc_mepc", 12'h341, 64'h8000_0010);
        expect_csr("exc_mcause", 12'h342, 64'h2);
        expect_csr("exc_mtval", 12'h343, 64'hdead);
        expect_csr("exc_mstatus", 12'h300, 64'h1800);
        drain();

        // Vectored interrupt taken on a NONE commit.
        apply_stimulus(3'd1, 12'h305, 64'h201, 64'h0, 4'd0, 64'h0);
        drain();
        apply_stimulus(3'd1, 12'h304, 64'h80, 64'h0, 4'd0, 64'h0);
        drain();
        apply_stimulus(3'd2, 12'h300, 64'h8, 64'h0, 4'd0, 64'h0);
        drain();
        irq = 12'h080;
        tick();
        apply_stimulus(3'd0, 12'h0, 64'h0, 64'h500, 4'd0, 64'h0);
        expect_redir("irq", 1'b1, 64'h21C);
        expect_csr("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
        expect_csr("irq_mepc", 12'h341, 64'h500);
        irq = '0;
        drain();

        // MRET down to U-mode.
        apply_stimulus(3'd1, 12'h300, 64'h80, 64'h0, 4'd0, 64'h0);
        drain();
        apply_stimulus(3'd5, 12'h0, 64'h0, 64'h777, 4'd0, 64'h0);
        expect_redir("mret", 1'b1, 64'h500);
        @(negedge clk);
        check_output("mret_priv", 64'(priv), 64'd0);
        #1;
        expect_csr("mret_mstatus", 12'h300, 64'h88);
        drain();

        // ECALL from U beats a pending interrupt.
        apply_stimulus(3'd1, 12'h304, 64'h880, 64'h0, 4'd0, 64'h0);
        drain();
        irq = 12'h800;
        tick();
        apply_stimulus(3'd4, 12'h0, 64'h0, 64'h600, 4'd0, 64'h1234);
        expect_redir("ecall", 1'b1, 64'h200);
        expect_csr("ecall_mcause", 12'h342, 64'h8);
        expect_csr("ecall_mtval", 12'h343, 64'h0);
        @(negedge clk);
        check_output("ecall_priv", 64'(priv), 64'd3);
        #1;
        irq = '0;
        drain();

        // CSRRS with zero operand, then a long-held redirect.
        apply_stimulus(3'd1, 12'h340, 64'h1234, 64'h0, 4'd0, 64'h0);
        drain();
        saved = m_minstret;
        apply_stimulus(3'd2, 12'h340, 64'h0, 64'h40, 4'd0, 64'h0);
        expect_csr("csrrs0_mscratch", 12'h340, 64'h1234);
        expect_csr("csrrs0_minstret", 12'hB02, saved + 64'd1);
        for (int i = 0; i < 5; i++) expect_redir("hold", 1'b1, 64'h44);
        drain();
        expect_redir("released", 1'b0, 64'h0);

        // Reset abandons a pending redirect.
        apply_stimulus(3'd1, 12'h340, 64'h55, 64'h80, 4'd0, 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_redir("reset_redir", 1'b0, 64'h0);
        expect_csr("reset_mscratch", 12'h340, 64'h0);
        expect_csr("reset_mtvec", 12'h305, 64'h0);

        for (int c = 0; c < 4000; c++) begin
            cm_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            if (r < 2)       cm_op = 3'd0;
            else if (r < 10) cm_op = 3'($urandom_range(1, 3));
            else if (r < 12) cm_op = 3'd4;
            else if (r < 14) cm_op = 3'd5;
            else             cm_op = 3'd6;
            cm_addr  = addr_tab[$urandom_range(0, 11)];
            cm_wdata = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            cm_pc    = {$urandom, $urandom};
            cm_cause = 4'($urandom_range(0, 15));
            cm_tval  = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) irq = NIRQ'($urandom);
            redir_ready = 1'($urandom_range(0, 1));
            rd_addr = addr_tab[$urandom_range(0, 11)];
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        cm_valid = 1'b0;
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter XLEN, default 64: CSR and PC width; legal values are 32 and 64.
REQ-002 Parameter NIRQ, default 12: number of interrupt lines, mapped to mip/mie bits [NIRQ-1:0]; legal range is 1..16.
REQ-003 Parameter VEC_EN, default 1: when 1, vectored mtvec mode is supported.
REQ-004 Parameter RESET_VEC, default 0: reset value of mtvec.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 rd_addr  in  12  combinational CSR read address.
REQ-008 rd_data  out  XLEN  read data; 0 for unimplemented addresses.
REQ-009 cm_valid  in  1  commit-stage instruction valid.
REQ-010 cm_ready  out  1  unit can accept a commit.
REQ-011 cm_op  in  3  operation: 0 NONE, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 ECALL, 5 MRET, 6 EXC.
REQ-012 cm_pc  in  XLEN  PC of the committing instruction.
REQ-013 cm_addr  in  12  CSR address.
REQ-014 cm_wdata  in  XLEN  CSR operand.
REQ-015 cm_cause  in  4  exception code; used only for EXC.
REQ-016 cm_tval  in  XLEN  trap value; used only for EXC.
REQ-017 irq  in  NIRQ  level-sensitive interrupt lines.
REQ-018 redir_valid  out  1  redirect request to fetch.
REQ-019 redir_ready  in  1  fetch accepts the redirect.
REQ-020 redir_pc  out  XLEN  redirect target.
REQ-021 priv  out  2  current privilege level: 3 = M, 0 = U.

Function
REQ-022 Implemented registers: mstatus (MIE bit 3, MPIE bit 7, MPP [12:11], all other bits 0), mie, mip, mtvec, mepc, mcause, mtval, mscratch, mcycle, minstret.
REQ-023 mip[NIRQ-1:0] SHALL register irq every cycle; mip is read-only and writes to it are ignored.
REQ-024 mepc[1:0] SHALL always be 0; mtvec[1] SHALL always be 0; mtvec[0] SHALL be forced to 0 when VEC_EN = 0.
REQ-025 A commit is accepted on a cycle where cm_valid && cm_ready; the FSM has two states: IDLE (cm_ready = 1) and REDIR (cm_ready = 0).
REQ-026 Accepted commit evaluation SHALL use one priority order: EXC/ECALL, then pending interrupt, then CSR op, then MRET, then NONE.
REQ-027 An interrupt is pending when (mip & mie) != 0 and (priv < 3 or mstatus.MIE = 1); the highest set bit index wins.
REQ-028 A trap SHALL perform all of the following on the acceptance edge:
- mepc = cm_pc
- mcause = {interrupt flag in bit XLEN-1, code}; code is cm_cause for EXC, 8 for ECALL from U, 11 for ECALL from M, the bit index for an interrupt
- mtval = cm_tval for EXC, otherwise 0
- MPIE = MIE, MIE = 0, MPP = priv, priv = 3
REQ-029 Trap target SHALL be {mtvec[XLEN-1:2], 2'b00}, plus 4*code when mtvec[0] = 1 and the trap is an interrupt.
REQ-030 On an accepted CSR op:
- CSRRW writes cm_wdata
- CSRRS writes old | cm_wdata
- CSRRC writes old & ~cm_wdata
- CSRRS/CSRRC with cm_wdata = 0 perform no write
- target is cm_pc + 4
REQ-031 On an accepted MRET: MIE = MPIE, MPIE = 1, priv = MPP, MPP = 0, target = mepc.
REQ-032 Trap, CSR op and MRET SHALL move the FSM to REDR on the next edge with redir_valid = 1 and redir_pc registered; NONE stays in IDLE.
REQ-033 In REDIR, redir_valid and redir_pc SHALL hold stable until redir_ready = 1; the FSM returns to IDLE on that edge.
REQ-034 mcycle SHALL increment by 1 every cycle and wrap at 2^XLEN; a CSR write to mcycle in the same cycle takes precedence.
REQ-035 minstret SHALL increment on each accepted non-trapping commit (including NONE); a CSR write takes precedence, and a trapped commit does not count.
REQ-036 Writes to unimplemented addresses SHALL be ignored, with the redirect still issued.
REQ-037 rd_data SHALL return the current registered value; writes become visible the cycle after acceptance.

Reset
REQ-038 reset SHALL clear all CSRs to 0 except mtvec = RESET_VEC, and set priv = 3, FSM = IDLE, redir_valid = 0, cm_ready = 1.
REQ-039 reset asserted while in REDIR SHALL abandon the pending redirect with no fetch handshake.

Verification
REQ-040 mtvec = 0x100 direct; EXC, cause 2, pc 0x8000_0010, tval 0xdead -> next cycle redir_pc = 0x100; mepc = 0x8000_0010, mcause = 2, mtval = 0xdead, MIE = 0.
REQ-041 mtvec = 0x201 vectored, mie[7] = 1, MIE = 1; raise irq[7] with a NONE commit -> redir_pc = 0x21C; mcause = 2^63 + 7.
REQ-042 Simultaneous ECALL (priv = 0) and pending irq[11] -> ECALL wins; mcause = 8, priv = 3.
REQ-043 CSRRS mscratch with wdata = 0 at pc 0x40 -> mscratch unchanged; redir_pc = 0x44; minstret increments by 1.
REQ-044 Hold redir_ready = 0 for 5 cycles -> redir_valid/redir_pc stable and cm_ready = 0 for all 5; ready = 1 -> IDLE next cycle.
REQ-045 MRET with MPP = 0, MPIE = 1 -> priv = 0, MIE = 1, redir_pc = mepc; assert reset while in REDIR -> redir_valid = 0 next cycle.
